// File: rtl/intr_arb_pkg.sv
// Shared types and helpers for the interrupt arbiter.
package intr_arb_pkg;

    // Handshake states: waiting for ack, waiting for vector, presenting vector
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    // Upper bound on NLEVELS*NDEV supported by the one-hot helper
    localparam int GRANT_MAX = 1024;

    // Width needed to index n items; never less than one bit
    function automatic int clog2w(input int n);
        int w;
        for (w = 0; (1 << w) < n; w++) begin
        end
        return (w < 1) ? 1 : w;
    endfunction

    // One-hot grant vector for device dev at level lvl (caller casts to its width)
    function automatic logic [GRANT_MAX-1:0] to_onehot(input int lvl, input int dev,
                                                        input int ndev);
        logic [GRANT_MAX-1:0] one;
        one = {{(GRANT_MAX-1){1'b0}}, 1'b1};
        return one << (lvl * ndev + dev);
    endfunction

endpackage

// File: rtl/intr_arb_prio_pick.sv
// Per-level device picker: first requesting device at or after ptr, wrapping.
// With ptr tied to zero this reduces to a fixed lowest-index priority encoder.
module prio_pick #(
    parameter int NDEV = 4,
    parameter int PW   = 2
) (
    input  logic [NDEV-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            any,
    output logic [PW-1:0]   idx
);

    // Scan devices starting from ptr and keep the first requester
    always_comb begin
        int unsigned j;
        any = 1'b0;
        idx = '0;
        for (int k = 0; k < NDEV; k++) begin
            j = (int'(ptr) + k) % NDEV;
            if (!any && req[j]) begin
                any = 1'b1;
                idx = PW'(j);
            end
        end
    end

endmodule

// File: rtl/intr_arb.sv
// Interrupt arbiter: picks the highest eligible level above the CPU IPL,
// grants one device on CPU ack, captures its vector and presents it.
// Optional macro INTR_ARB_RR_EN: round-robin device selection within a level
// (per-level pointer advanced past the winner on each successful capture).
module intr_arb
    import intr_arb_pkg::*;
#(
    parameter int NLEVELS = 8,
    parameter int NDEV    = 4,
    parameter int VEC_W   = 9,
    parameter int TMO     = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [clog2w(NLEVELS)-1:0]         ipl,
    input  logic [NLEVELS*NDEV-1:0]            req,
    output logic                               int_pending,
    input  logic                               int_ack,
    output logic [NLEVELS*NDEV-1:0]            grant,
    input  logic                               dev_vec_valid,
    input  logic [VEC_W-1:0]                   dev_vec,
    output logic                               vec_valid,
    output logic [VEC_W-1:0]                   vec,
    output logic [clog2w(NLEVELS)-1:0]         vec_level,
    input  logic                               vec_taken,
    output logic                               timeout_err
);

    localparam int LW = clog2w(NLEVELS);
    localparam int DW = clog2w(NDEV);
    localparam int GW = NLEVELS * NDEV;
    localparam int CW = clog2w(TMO);

    state_t                        state;
    logic [CW-1:0]                 cnt;
    logic [LW-1:0]                 lvl_q;
    logic [NLEVELS-1:0]            lvl_any;
    logic [NLEVELS-1:0][DW-1:0]    lvl_idx;
    logic [NLEVELS-1:0][DW-1:0]    lvl_ptr;
    logic                          any_elig;
    logic [LW-1:0]                 win_lvl;
    logic [DW-1:0]                 win_dev;

`ifdef INTR_ARB_RR_EN
    logic [DW-1:0]                 dev_q;
`else
    assign lvl_ptr = '0;
`endif

    // One device picker per level
    for (genvar l = 0; l < NLEVELS; l++) begin : g_lvl
        prio_pick #(.NDEV(NDEV), .PW(DW)) u_pick (
            .req (req[l*NDEV +: NDEV]),
            .ptr (lvl_ptr[l]),
            .any (lvl_any[l]),
            .idx (lvl_idx[l])
        );
    end

    // Highest eligible level wins; level 0 can never beat any IPL
    always_comb begin
        any_elig = 1'b0;
        win_lvl  = '0;
        win_dev  = '0;
        for (int l = 1; l < NLEVELS; l++) begin
            if (lvl_any[l] && (LW'(l) > ipl)) begin
                any_elig = 1'b1;
                win_lvl  = LW'(l);
                win_dev  = lvl_idx[l];
            end
        end
    end

    // Handshake FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            int_pending <= 1'b0;
            grant       <= '0;
            vec_valid   <= 1'b0;
            vec         <= '0;
            vec_level   <= '0;
            timeout_err <= 1'b0;
            cnt         <= '0;
            lvl_q       <= '0;
`ifdef INTR_ARB_RR_EN
            dev_q       <= '0;
            lvl_ptr     <= '0;
`endif
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    // Winner is re-evaluated at ack; a vanished request is a passive release
                    if (int_ack && int_pending && any_elig) begin
                        state       <= GRANT;
                        grant       <= GW'(to_onehot(int'(win_lvl), int'(win_dev), NDEV));
                        lvl_q       <= win_lvl;
`ifdef INTR_ARB_RR_EN
                        dev_q       <= win_dev;
`endif
                        cnt         <= '0;
                        int_pending <= 1'b0;
                    end else begin
                        int_pending <= any_elig;
                    end
                end
                GRANT: begin
                    int_pending <= 1'b0;
                    // Capture has priority over a coincident timeout
                    if (dev_vec_valid) begin
                        vec       <= dev_vec;
                        vec_level <= lvl_q;
                        vec_valid <= 1'b1;
                        grant     <= '0;
                        state     <= PRESENT;
`ifdef INTR_ARB_RR_EN
                        lvl_ptr[lvl_q] <= (dev_q == DW'(NDEV - 1)) ? '0 : dev_q + 1'b1;
`endif
                    end else if (cnt == CW'(TMO - 1)) begin
                        grant       <= '0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESENT: begin
                    int_pending <= 1'b0;
                    if (vec_taken) begin
                        vec_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intr_arb.sv
// Directed bench for intr_arb with default parameters.
module tb_intr_arb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  ipl = '0;
    logic [31:0] req = '0;
    logic        int_pending;
    logic        int_ack = 1'b0;
    logic [31:0] grant;
    logic        dev_vec_valid = 1'b0;
    logic [8:0]  dev_vec = '0;
    logic        vec_valid;
    logic [8:0]  vec;
    logic [2:0]  vec_level;
    logic        vec_taken = 1'b0;
    logic        timeout_err;

    int n_chk  = 0;
    int n_fail = 0;

    intr_arb #(.NLEVELS(8), .NDEV(4), .VEC_W(9), .TMO(16)) dut (
        .clk(clk), .reset(reset), .ipl(ipl), .req(req),
        .int_pending(int_pending), .int_ack(int_ack), .grant(grant),
        .dev_vec_valid(dev_vec_valid), .dev_vec(dev_vec),
        .vec_valid(vec_valid), .vec(vec), .vec_level(vec_level),
        .vec_taken(vec_taken), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
    endtask

    task automatic capture(input logic [8:0] v);
        dev_vec = v;
        dev_vec_valid = 1'b1;
        tick(1);
        dev_vec_valid = 1'b0;
    endtask

    task automatic take();
        vec_taken = 1'b1;
        tick(1);
        vec_taken = 1'b0;
    endtask

    logic [31:0] exp_g [4];

    initial begin
        tick(2);
        chk("rst_pend", int_pending, 0);
        chk("rst_grant", grant, 0);
        chk("rst_vvalid", vec_valid, 0);
        chk("rst_vec", vec, 0);
        chk("rst_lvl", vec_level, 0);
        chk("rst_tmo", timeout_err, 0);
        reset = 1'b0;

        // Basic sequence at L5 d0
        ipl = 3'd4; req = 32'h1 << 20;
        tick(1);
        chk("t1_pend", int_pending, 1);
        ack();
        chk("t1_grant", grant, 64'h1 << 20);
        chk("t1_pend_gr", int_pending, 0);
        capture(9'o060);
        chk("t1_vvalid", vec_valid, 1);
        chk("t1_vec", vec, 9'o060);
        chk("t1_lvl", vec_level, 5);
        chk("t1_grant_off", grant, 0);
        req = '0;
        take();
        chk("t1_taken", vec_valid, 0);
        chk("t1_vec_hold", vec, 9'o060);

        // IPL masking
        ipl = 3'd5; req = (32'h1 << 20) | (32'h1 << 8);
        tick(2);
        chk("t2_masked", int_pending, 0);
        ipl = 3'd4;
        tick(1);
        chk("t2_pend", int_pending, 1);
        ack();
        chk("t2_grant", grant, 64'h1 << 20);
        capture(9'o101);
        chk("t2_lvl", vec_level, 5);
        req = '0;
        take();
        ipl = 3'd7; req = 32'h1 << 28;
        tick(2);
        chk("t2_ipl7", int_pending, 0);
        req = '0; ipl = 3'd0;
        tick(1);

        // Timeout: grant drops 16 cycles after rising
        req = 32'h1 << 4;
        tick(1);
        chk("t3_pend", int_pending, 1);
        ack();
        chk("t3_grant", grant, 64'h1 << 4);
        tick(15);
        chk("t3_hold", grant, 64'h1 << 4);
        chk("t3_no_tmo", timeout_err, 0);
        tick(1);
        chk("t3_drop", grant, 0);
        chk("t3_tmo", timeout_err, 1);
        chk("t3_vvalid", vec_valid, 0);
        tick(1);
        chk("t3_tmo_pulse", timeout_err, 0);
        chk("t3_idle_pend", int_pending, 1);
        req = '0;
        tick(1);

        // Passive release: request gone at ack
        req = 32'h1 << 12;
        tick(1);
        chk("t4_pend", int_pending, 1);
        req = '0;
        ack();
        chk("t4_nogrant", grant, 0);
        chk("t4_pend0", int_pending, 0);
        capture(9'o007);
        chk("t4_stray_vec", vec_valid, 0);
        req = 32'h1 << 12;
        tick(1);
        chk("t4_idle", int_pending, 1);
        req = '0;
        tick(1);

        // Within-level selection at L3, devices 1..3
`ifdef INTR_ARB_RR_EN
        exp_g = '{32'h1 << 13, 32'h1 << 14, 32'h1 << 15, 32'h1 << 13};
`else
        exp_g = '{32'h1 << 13, 32'h1 << 13, 32'h1 << 13, 32'h1 << 13};
`endif
        req = (32'h1 << 13) | (32'h1 << 14) | (32'h1 << 15);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk($sformatf("t5_pend%0d", i), int_pending, 1);
            ack();
            chk($sformatf("t5_grant%0d", i), grant, exp_g[i]);
            capture(9'(i + 1));
            take();
        end
        req = '0;
        tick(1);

        // Reset during PRESENT, then a clean sequence
        ipl = 3'd4; req = 32'h1 << 20;
        tick(1);
        ack();
        capture(9'o777);
        chk("t6_present", vec_valid, 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t6_vvalid", vec_valid, 0);
        chk("t6_vec", vec, 0);
        chk("t6_lvl", vec_level, 0);
        chk("t6_grant", grant, 0);
        chk("t6_pend", int_pending, 0);
        chk("t6_tmo", timeout_err, 0);
        tick(1);
        chk("t6_re_pend", int_pending, 1);
        ack();
        chk("t6_re_grant", grant, 64'h1 << 20);
        capture(9'o123);
        chk("t6_re_vec", vec, 9'o123);
        chk("t6_re_lvl", vec_level, 5);
        req = '0;
        take();
        chk("t6_re_taken", vec_valid, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
